// File: rtl/sobel_pkg.sv
// Shared widths, pixel/word types and the gradient magnitude helper
// for the Sobel output buffer.
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int GRAD_W = 16;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [WORD_W-1:0] word_t;

  // |gx|+|gy| in GRAD_W+1 bits, saturated to 255.
  // Negation is done one bit wider so |-32768| is 32768.
  function automatic pix_t sat_mag(
    input logic [GRAD_W-1:0] gx,
    input logic [GRAD_W-1:0] gy
  );
    logic [GRAD_W:0] ax;
    logic [GRAD_W:0] ay;
    logic [GRAD_W:0] sum;
    ax = gx[GRAD_W-1] ? (~{1'b1, gx} + (GRAD_W+1)'(1))
                      : {1'b0, gx};
    ay = gy[GRAD_W-1] ? (~{1'b1, gy} + (GRAD_W+1)'(1))
                      : {1'b0, gy};
    sum = ax + ay;
    return (sum > (GRAD_W+1)'(255)) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, power-of-2 depth.
// Ports: i_wr_en/i_wr_data push, i_rd_en pop, o_rd_data head, o_full, o_empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);

  // A pop frees the head slot on the same edge, so a push when
  // full is accepted if a pop coincides.
  assign w_pop  = i_rd_en && !o_empty;
  assign w_push = i_wr_en && (!o_full || w_pop);

  assign o_rd_data = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/sobel_out_buffer.sv
// Sobel output buffer: magnitude, optional binarize (SOBEL_BINARIZE_EN),
// 4-pixel packing, FWFT FIFO, frame_done pulse and sticky overflow.
module sobel_out_buffer
  import sobel_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int PIX_PER_FRAME = 900,
  parameter int THRESH        = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              frame_done,
  output logic              overflow
);

  localparam int CNT_W = $clog2(PIX_PER_FRAME + 1);

  pix_t             w_mag;
  pix_t             w_pix;
  logic             w_in_last;
  pix_t             r_pix;
  logic             r_pix_v;
  logic             r_pix_last;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [1:0]       r_lane;
  word_t            r_pack;
  word_t            w_word;
  logic             w_wr;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WORD_W:0]  w_head;
  logic             r_ovf;

  assign w_mag = sat_mag(in_word[31:16], in_word[15:0]);

`ifdef SOBEL_BINARIZE_EN
  assign w_pix = (w_mag >= pix_t'(THRESH)) ? 8'hFF : 8'h00;
`else
  assign w_pix = w_mag;
`endif

  assign w_in_last = (r_pix_cnt == CNT_W'(PIX_PER_FRAME - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix      <= '0;
      r_pix_v    <= 1'b0;
      r_pix_last <= 1'b0;
      r_pix_cnt  <= '0;
    end else begin
      r_pix_v <= in_valid;
      if (in_valid) begin
        r_pix      <= w_pix;
        r_pix_last <= w_in_last;
        r_pix_cnt  <= w_in_last ? '0 : r_pix_cnt + CNT_W'(1);
      end
    end
  end

  // The stage-1 pixel is merged combinationally, so a full word
  // (or a frame-end partial word) goes to the FIFO on the next edge.
  assign w_word = r_pack | (word_t'(r_pix) << {r_lane, 3'b000});
  assign w_wr   = r_pix_v && ((r_lane == 2'd3) || r_pix_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (r_pix_v) begin
      if (w_wr) begin
        r_lane <= '0;
        r_pack <= '0;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_pack <= w_word;
      end
    end
  end

  // Bit WORD_W marks the word holding the frame's last pixel.
  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_data ({r_pix_last, w_word}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign out_valid  = !w_empty && !rst;
  assign w_pop      = out_valid && out_ready;
  assign out_data   = out_valid ? w_head[WORD_W-1:0] : '0;
  assign frame_done = w_pop && w_head[WORD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_wr && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  assign overflow = r_ovf && !rst;

endmodule

// File: tb/tb_sobel_out_buffer.sv
// Scoreboard bench for sobel_out_buffer (FIFO_DEPTH=2, PIX_PER_FRAME=6).
// Expected words follow SOBEL_BINARIZE_EN when it is defined.
module tb_sobel_out_buffer;
  import sobel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        frame_done;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  sobel_out_buffer #(
    .FIFO_DEPTH    (2),
    .PIX_PER_FRAME (6),
    .THRESH        (128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] px(input int m);
`ifdef SOBEL_BINARIZE_EN
    return (m >= 128) ? 8'hFF : 8'h00;
`else
    return (m > 255) ? 8'hFF : 8'(m);
`endif
  endfunction

  function automatic logic [31:0] w4(input int a, input int b,
                                     input int c, input int d);
    return {px(d), px(c), px(b), px(a)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int gx, input int gy);
    in_valid = 1'b1;
    in_word  = {gx[15:0], gy[15:0]};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step(1);
    @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step(1);
      k++;
    end
    step(2);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : mon
    logic        hold;
    logic [31:0] hold_d;
    logic [32:0] e;
    hold = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold && out_valid) chk("hold data", out_data, hold_d);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra pop: got %h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("pop data", out_data, e[31:0]);
            chk("pop frame_done", {31'b0, frame_done}, {31'b0, e[32]});
          end
        end else begin
          chk("idle frame_done", {31'b0, frame_done}, 32'd0);
        end
        hold = out_valid && !out_ready;
        hold_d = out_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    rst_pulse();

    // mixed signs, saturation and |-32768|, plus 2-cycle latency
    out_ready = 1'b1;
    exp_q.push_back({1'b0, w4(7, 0, 300, 32769)});
    send(3, -4);
    send(0, 0);
    send(300, 0);
    send(-32768, -1);
    @(negedge clk);
    chk("latency +1", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("latency +2", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // threshold edges 127/128
    rst_pulse();
    exp_q.push_back({1'b0, w4(127, 128, 200, 0)});
    send(127, 0);
    send(0, -128);
    send(100, -100);
    send(0, 0);
    drain();

    // frame end flush and lane restart
    rst_pulse();
    exp_q.push_back({1'b0, w4(1, 2, 3, 4)});
    exp_q.push_back({1'b1, w4(5, 6, 0, 0)});
    exp_q.push_back({1'b0, w4(9, 10, 11, 12)});
    send(1, 0);
    send(0, -2);
    send(-1, -2);
    send(4, 0);
    send(2, 3);
    send(-3, -3);
    send(9, 0);
    send(10, 0);
    send(0, 11);
    send(-12, 0);
    drain();

    // overflow with downstream stalled
    rst_pulse();
    out_ready = 1'b0;
    exp_q.push_back({1'b0, w4(1, 2, 3, 4)});
    exp_q.push_back({1'b1, w4(5, 6, 0, 0)});
    for (int k = 1; k <= 12; k++) send(k, 0);
    step(3);
    @(negedge clk);
    chk("ovf set", {31'b0, overflow}, 32'd1);
    step(5);
    @(negedge clk);
    chk("ovf sticky", {31'b0, overflow}, 32'd1);
    chk("full valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("ovf empty valid", {31'b0, out_valid}, 32'd0);
    chk("ovf after drain", {31'b0, overflow}, 32'd1);
    @(posedge clk);
    #1;

    // push and pop on the same edge while full
    rst_pulse();
    out_ready = 1'b0;
    exp_q.push_back({1'b0, w4(1, 2, 3, 4)});
    exp_q.push_back({1'b1, w4(5, 6, 0, 0)});
    exp_q.push_back({1'b0, w4(7, 8, 9, 10)});
    for (int k = 1; k <= 6; k++) send(k, 0);
    step(3);
    @(negedge clk);
    chk("pre full valid", {31'b0, out_valid}, 32'd1);
    chk("pre full ovf", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    for (int k = 7; k <= 10; k++) send(k, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("push+pop ovf", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("push+pop ovf end", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1;

    // reset mid-word discards the partial pixels
    rst_pulse();
    send(17, 0);
    send(34, 0);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    chk("mid rst valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back({1'b0, w4(51, 144, 165, 102)});
    send(51, 0);
    send(0, 144);
    send(-165, 0);
    send(100, 2);
    drain();

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
